// File: rtl/product_pkg.sv
// Shared constants and state encoding for the sequential product engine.
package product_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int OP_W   = 16;

  localparam int N_LOAD  = 4;
  localparam int N_MUL   = 16;
  localparam int N_STORE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MUL   = 2'd2,
    STORE = 2'd3
  } state_t;

endpackage

// File: rtl/product_if.sv
// Host-side request/completion signals of the product engine.
interface product_if #(
  parameter int ADDR_W = product_pkg::ADDR_W
);

  logic              start;
  logic [ADDR_W-1:0] start_address;
  logic              done;

  modport master (output start, output start_address, input done);
  modport slave  (input start, input start_address, output done);

endinterface

// File: rtl/product_dmem.sv
// Byte-wide data memory: combinational read, rising-edge write, never cleared.
module product_dmem #(
  parameter int ADDR_W = product_pkg::ADDR_W,
  parameter int DATA_W = product_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  import product_pkg::*;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/product_top.sv
// Product engine: loads two big-endian operands from memory, multiplies them
// with a shift-add loop and writes the 32-bit product back after them.
module product_top #(
  parameter int ADDR_W = product_pkg::ADDR_W,
  parameter int DATA_W = product_pkg::DATA_W,
  parameter int OP_W   = product_pkg::OP_W
) (
  input  logic     clock,
  input  logic     reset,
  product_if.slave bus
);
  import product_pkg::*;

  localparam int CNT_W  = $clog2(N_MUL);
  localparam int BYTE_W = $clog2(N_STORE);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic                cnt_last;
  logic [ADDR_W-1:0]   base_reg;
  logic [OP_W-1:0]     a_reg, b_reg;
  logic [2*OP_W-1:0]   acc_reg;
  logic                done_reg;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_raddr, mem_waddr;
  logic [DATA_W-1:0]   mem_rdata, mem_wdata;
  logic [DATA_W-1:0]   prod_byte [N_STORE];

  // Byte 0 is the most significant, matching the big-endian result layout.
  genvar gi;
  generate
    for (gi = 0; gi < N_STORE; gi++) begin : g_prod_byte
      assign prod_byte[gi] = acc_reg[(N_STORE-1-gi)*DATA_W +: DATA_W];
    end
  endgenerate

  product_dmem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dm (
    .clock (clock),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_last   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        cnt_last = (cnt_reg == CNT_W'(N_LOAD - 1));
        if (cnt_last) begin
          state_next = MUL;
        end
      end
      MUL: begin
        cnt_last = (cnt_reg == CNT_W'(N_MUL - 1));
        if (cnt_last) begin
          state_next = STORE;
        end
      end
      STORE: begin
        cnt_last = (cnt_reg == CNT_W'(N_STORE - 1));
        if (cnt_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands sit at S..S+3; the product follows immediately at S+4..S+7.
  always_comb begin
    mem_we    = (state_reg == STORE);
    mem_raddr = base_reg + ADDR_W'(cnt_reg);
    mem_waddr = base_reg + ADDR_W'(N_LOAD) + ADDR_W'(cnt_reg);
    mem_wdata = prod_byte[cnt_reg[BYTE_W-1:0]];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg  <= '0;
      base_reg <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      acc_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (bus.start) begin
            base_reg <= bus.start_address;
            done_reg <= 1'b0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
          end
        end
        LOAD: begin
          // Shift bytes in from the right so S lands in A's high byte.
          {a_reg, b_reg} <= {a_reg[OP_W-DATA_W-1:0], b_reg, mem_rdata};
          cnt_reg        <= cnt_last ? '0 : cnt_reg + CNT_W'(1);
        end
        MUL: begin
          if (b_reg[0]) begin
            acc_reg <= acc_reg + ({{OP_W{1'b0}}, a_reg} << cnt_reg);
          end
          b_reg   <= b_reg >> 1;
          cnt_reg <= cnt_last ? '0 : cnt_reg + CNT_W'(1);
        end
        STORE: begin
          cnt_reg <= cnt_last ? '0 : cnt_reg + CNT_W'(1);
          if (cnt_last) begin
            done_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.done = done_reg;

endmodule

// File: tb/tb_product_top.sv
// Directed bench for product_top: vector table plus start-ignore, reset and
// held-start sequences, with memory preloaded and checked through uut.dm.mem.
module tb_product_top;
  import product_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  product_if bus ();

  product_top uut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [6:0]  s;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [7:0] sentinel(input int i);
    return 8'((i * 13 + 5) & 255);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 128; i++) uut.dm.mem[i] = sentinel(i);
  endtask

  task automatic poke_ops(input logic [6:0] s, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] ab;
    logic [6:0]  idx;
    ab = {a, b};
    for (int k = 0; k < 4; k++) begin
      idx = s + 7'(k);
      uut.dm.mem[idx] = ab[8*(3-k) +: 8];
    end
  endtask

  task automatic read_word(input logic [6:0] base, output logic [31:0] w);
    logic [6:0] idx;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      idx = base + 7'(k);
      w   = {w[23:0], uut.dm.mem[idx]};
    end
  endtask

  task automatic pulse_start(input logic [6:0] s);
    bus.start_address = s;
    bus.start         = 1'b1;
    @(posedge clock);
    #1;
    bus.start         = 1'b0;
    bus.start_address = 'x;
  endtask

  // Called #1 after the accepting edge plus `used` further edges.
  task automatic wait_done(input int used, input string tag);
    repeat (23 - used) @(posedge clock);
    #1 check({tag, "_done_early"}, 32'(bus.done), 32'd0);
    @(posedge clock);
    #1 check({tag, "_done_on_time"}, 32'(bus.done), 32'd1);
  endtask

  task automatic check_result(input logic [6:0] s, input logic [31:0] p, input string tag);
    logic [31:0] got;
    logic [6:0]  idx;
    read_word(s + 7'd4, got);
    check({tag, "_product"}, got, p);
    idx = s - 7'd1;
    check({tag, "_below_untouched"}, 32'(uut.dm.mem[idx]), 32'(sentinel(int'(idx))));
    idx = s + 7'd8;
    check({tag, "_above_untouched"}, 32'(uut.dm.mem[idx]), 32'(sentinel(int'(idx))));
    $display("op %s S=%02h result=%08h expected=%08h", tag, s, got, p);
  endtask

  initial begin
    logic [31:0] w;

    vecs[0] = '{7'h00, 16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1] = '{7'h10, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{7'h20, 16'h0000, 16'h1234, 32'h0000_0000};
    vecs[3] = '{7'h7C, 16'h0002, 16'h0003, 32'h0000_0006};
    vecs[4] = '{7'h40, 16'h1234, 16'h5678, 32'h0626_0060};
    vecs[5] = '{7'h50, 16'h8000, 16'h0002, 32'h0001_0000};
    vecs[6] = '{7'h60, 16'hABCD, 16'h0001, 32'h0000_ABCD};

    bus.start         = 1'b0;
    bus.start_address = '0;
    reset             = 1'b1;
    repeat (3) @(posedge clock);
    #1 check("reset_done", 32'(bus.done), 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      fill_mem();
      poke_ops(vecs[v].s, vecs[v].a, vecs[v].b);
      pulse_start(vecs[v].s);
      check($sformatf("vec%0d_done_cleared", v), 32'(bus.done), 32'd0);
      wait_done(0, $sformatf("vec%0d", v));
      check_result(vecs[v].s, vecs[v].p, $sformatf("vec%0d", v));
    end

    // Asynchronous reset drops a held done without waiting for an edge.
    #2 reset = 1'b1;
    #1 check("async_reset_done", 32'(bus.done), 32'd0);
    @(negedge clock) reset = 1'b0;

    // A second start five edges into a run must be ignored.
    fill_mem();
    poke_ops(7'h30, 16'h0007, 16'h0009);
    pulse_start(7'h30);
    repeat (4) @(posedge clock);
    #1 pulse_start(7'h00);
    wait_done(5, "ignore");
    check_result(7'h30, 32'h0000_003F, "ignore");
    read_word(7'h04, w);
    check("ignore_alt_base_untouched", w,
          {sentinel(4), sentinel(5), sentinel(6), sentinel(7)});

    // Reset ten edges into a run: nothing written, engine stays idle.
    fill_mem();
    poke_ops(7'h48, 16'h0011, 16'h0011);
    pulse_start(7'h48);
    repeat (9) @(posedge clock);
    #1 reset = 1'b1;
    #1 check("midrun_reset_done", 32'(bus.done), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    read_word(7'h4C, w);
    check("midrun_no_write", w,
          {sentinel(8'h4C), sentinel(8'h4D), sentinel(8'h4E), sentinel(8'h4F)});
    repeat (30) @(posedge clock);
    #1 check("midrun_stays_idle", 32'(bus.done), 32'd0);
    pulse_start(7'h48);
    wait_done(0, "after_reset");
    check_result(7'h48, 32'h0000_0121, "after_reset");

    // Start held high: back-to-back runs, done high for exactly one cycle.
    fill_mem();
    poke_ops(7'h58, 16'h0003, 16'h0004);
    bus.start_address = 7'h58;
    bus.start         = 1'b1;
    @(posedge clock);
    #1;
    wait_done(0, "b2b_first");
    @(posedge clock);
    #1 check("b2b_done_one_cycle", 32'(bus.done), 32'd0);
    wait_done(0, "b2b_second");
    bus.start = 1'b0;
    @(posedge clock);
    #1 check("b2b_done_held", 32'(bus.done), 32'd1);
    check_result(7'h58, 32'h0000_000C, "b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/product_top.md
Name: product_top

Overview:
- Self-contained product engine.
- On a start pulse it reads two 16-bit unsigned operands from its internal 128x8 data memory at a caller-supplied base address.
- It multiplies them with a sequential shift-add datapath, writes the 32-bit product back to memory, then raises done.
- It is the top-level block of the product design, driven directly by the bench or host.

Parameters:
- ADDR_W, 7, data-memory address width; memory depth is 2**ADDR_W bytes.
- DATA_W, 8, memory word width in bits.
- OP_W, 16, operand width; product width is 2*OP_W.

Ports:
- clock  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request pulse, sampled on the rising clock edge
- start_address  input  ADDR_W  base byte address of the operand/result block
- done  output  1  high when the last operation is complete; held until the next accepted start or reset

Behaviour:
- Memory layout, relative to base S, addresses mod 128, big-endian:
  - A = {mem[S], mem[S+1]}
  - B = {mem[S+2], mem[S+3]}
  - P = A*B is written as mem[S+4]=P[31:24], mem[S+5]=P[23:16], mem[S+6]=P[15:8], mem[S+7]=P[7:0].
- Memory: combinational read, synchronous write on the rising edge. Contents are not cleared by reset.
- State machine: IDLE, LOAD, MUL, STORE. An internal counter indexes bytes (0-3) and iterations (0-15).
- IDLE:
  - On an edge with start=1: latch start_address, clear done, clear the accumulator, set counter to 0, go to LOAD.
  - Otherwise hold state and done.
- LOAD: capture one byte per edge into the A/B registers, in order S..S+3. After 4 edges go to MUL.
- MUL, one iteration per edge, 16 edges total, unsigned shift-add:
  - if B[0] is set, add A (shifted left by the iteration count) into the 32-bit accumulator;
  - shift B right by 1.
  - Then go to STORE.
- STORE: write one product byte per edge, S+4..S+7. On the 4th write edge go to IDLE and set done=1 on the same edge.
- Latency: if start is sampled at edge N, done is high after edge N+24 (4 load + 16 multiply + 4 store edges).
- start in any state other than IDLE is ignored; the latched address and operands are unaffected.
- start held high: a new operation is accepted at the first IDLE edge. For back-to-back runs, done is high for exactly that one cycle.
- Address arithmetic wraps modulo 128. With S=0x7C, the result lands at 0x00..0x03.
- The result is exact for all operands. No overflow is possible: 16x16 fits in 32 bits.
- Reset, asynchronous, any time:
  - state becomes IDLE, done=0, counter, A/B and accumulator become 0;
  - any in-progress write sequence is abandoned; bytes already written remain;
  - memory is not cleared.
- start_address is X-tolerant while in IDLE with start=0.

Decomposition:
- Package product_pkg:
  - ADDR_W, DATA_W and OP_W constants;
  - state enum typedef {IDLE, LOAD, MUL, STORE};
  - localparams N_LOAD=4, N_MUL=16, N_STORE=4.
- One sub-module, product_dmem: 2**ADDR_W x DATA_W array named mem, with async read port and sync write port.
  - Instance name dm, so benches preload and check via uut.dm.mem.
- The FSM and datapath stay in product_top.

Test Plan:
- Preload mem[0..3]=00,03,00,05; S=0; pulse start -> done rises 24 clocks later; mem[4..7]=00,00,00,0F.
- Operands FFFF x FFFF at S=0x10 -> mem[0x14..0x17]=FF,FE,00,01.
- Operands 0000 x 1234 at S=0x20 -> result 00000000; done timing identical.
- Wrap case: S=0x7C, operands 00,02,00,03 -> mem[0x00..0x03]=00,00,00,06; other bytes untouched.
- Pulse start again 5 cycles into a run with a different start_address -> ignored; first result correct; done at N+24 of the first start.
- Assert reset at cycle 10 of a run -> done=0 immediately; no result bytes written. A fresh start afterwards completes correctly.
